// File: rtl/line_raster_engine_pkg.sv
// Shared definitions for the line raster engine: canvas geometry, colour width,
// Bresenham arithmetic widths and the controller state encoding.
package line_raster_engine_pkg;

    localparam int COORD_W = 8;
    localparam int COLOR_W = 12;
    localparam int VRAM_AW = 2 * COORD_W;

    // Error term must hold dx+dy and its running sum without wrapping; e2 is 2*err.
    localparam int ERR_W = 11;
    localparam int E2_W  = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LINE  = 3'd2,
        FILL  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/line_raster_engine.sv
// Line raster engine: turns a pen stroke (x0,y0)->(x1,y1) into one VRAM pixel write
// per clock using Bresenham stepping, or fills the whole canvas with one colour.
//
// Ports
//   clk25MHz         system/pixel clock, rising edge
//   rst              asynchronous, active-high reset
//   start            stroke request (accepted only when idle)
//   clr              canvas-fill request (accepted only when idle, wins over start)
//   x0,y0,x1,y1      stroke endpoints, sampled on accept
//   color            stroke/fill colour, sampled on accept
//   busy             high while a stroke or fill is in progress
//   done             one-cycle pulse after the final write
//   we,waddr,wdata   VRAM write port, waddr = {y,x}
module line_raster_engine
    import line_raster_engine_pkg::*;
(
    input  logic                clk25MHz,
    input  logic                rst,
    input  logic                start,
    input  logic                clr,
    input  logic [COORD_W-1:0]  x0,
    input  logic [COORD_W-1:0]  y0,
    input  logic [COORD_W-1:0]  x1,
    input  logic [COORD_W-1:0]  y1,
    input  logic [COLOR_W-1:0]  color,
    output logic                busy,
    output logic                done,
    output logic                we,
    output logic [VRAM_AW-1:0]  waddr,
    output logic [COLOR_W-1:0]  wdata
);

    state_t                    state, state_n;
    logic [COORD_W-1:0]        cur_x, cur_x_n, cur_y, cur_y_n;
    logic [COORD_W-1:0]        end_x, end_x_n, end_y, end_y_n;
    logic [COLOR_W-1:0]        color_r, color_n;
    logic signed [ERR_W-1:0]   dx, dx_n, dy, dy_n, err, err_n;
    logic                      sx_neg, sx_neg_n, sy_neg, sy_neg_n;
    logic [VRAM_AW-1:0]        cnt, cnt_n;
    logic                      busy_n, done_n, we_n;
    logic [VRAM_AW-1:0]        waddr_n;
    logic [COLOR_W-1:0]        wdata_n;

    logic [COORD_W-1:0]        abs_dx, abs_dy;
    logic signed [E2_W-1:0]    e2, dx_ext, dy_ext;
    logic                      step_x, step_y;

    always_ff @(posedge clk25MHz or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cur_x   <= '0;
            cur_y   <= '0;
            end_x   <= '0;
            end_y   <= '0;
            color_r <= '0;
            dx      <= '0;
            dy      <= '0;
            err     <= '0;
            sx_neg  <= 1'b0;
            sy_neg  <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            we      <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
        end else begin
            state   <= state_n;
            cur_x   <= cur_x_n;
            cur_y   <= cur_y_n;
            end_x   <= end_x_n;
            end_y   <= end_y_n;
            color_r <= color_n;
            dx      <= dx_n;
            dy      <= dy_n;
            err     <= err_n;
            sx_neg  <= sx_neg_n;
            sy_neg  <= sy_neg_n;
            cnt     <= cnt_n;
            busy    <= busy_n;
            done    <= done_n;
            we      <= we_n;
            waddr   <= waddr_n;
            wdata   <= wdata_n;
        end
    end

    // Bresenham helpers; e2 and the compare operands are sign-extended to the same width.
    assign abs_dx = (end_x >= cur_x) ? end_x - cur_x : cur_x - end_x;
    assign abs_dy = (end_y >= cur_y) ? end_y - cur_y : cur_y - end_y;
    assign e2     = {err, 1'b0};
    assign dx_ext = {dx[ERR_W-1], dx};
    assign dy_ext = {dy[ERR_W-1], dy};
    assign step_x = (e2 >= dy_ext);
    assign step_y = (e2 <= dx_ext);

    // The outputs are registered from the next-state values so that the write
    // presented on the port always belongs to the state the engine is in.
    always_comb begin
        state_n  = state;
        cur_x_n  = cur_x;
        cur_y_n  = cur_y;
        end_x_n  = end_x;
        end_y_n  = end_y;
        color_n  = color_r;
        dx_n     = dx;
        dy_n     = dy;
        err_n    = err;
        sx_neg_n = sx_neg;
        sy_neg_n = sy_neg;
        cnt_n    = cnt;

        case (state)
            IDLE: begin
                if (clr) begin
                    color_n = color;
                    cnt_n   = '0;
                    state_n = FILL;
                end else if (start) begin
                    cur_x_n = x0;
                    cur_y_n = y0;
                    end_x_n = x1;
                    end_y_n = y1;
                    color_n = color;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                dx_n     = signed'({{(ERR_W-COORD_W){1'b0}}, abs_dx});
                dy_n     = -signed'({{(ERR_W-COORD_W){1'b0}}, abs_dy});
                sx_neg_n = (end_x < cur_x);
                sy_neg_n = (end_y < cur_y);
                err_n    = signed'({{(ERR_W-COORD_W){1'b0}}, abs_dx})
                         - signed'({{(ERR_W-COORD_W){1'b0}}, abs_dy});
                state_n  = LINE;
            end
            LINE: begin
                if (cur_x == end_x && cur_y == end_y) begin
                    state_n = DONE;
                end else begin
                    err_n = err + (step_x ? dy : '0) + (step_y ? dx : '0);
                    if (step_x) cur_x_n = sx_neg ? cur_x - 1'b1 : cur_x + 1'b1;
                    if (step_y) cur_y_n = sy_neg ? cur_y - 1'b1 : cur_y + 1'b1;
                end
            end
            FILL: begin
                if (cnt == '1) state_n = DONE;
                else           cnt_n   = cnt + 1'b1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        we_n    = (state_n == LINE) || (state_n == FILL);
        busy_n  = (state_n == SETUP) || (state_n == LINE) || (state_n == FILL);
        done_n  = (state_n == DONE);
        waddr_n = waddr;
        wdata_n = wdata;
        if (we_n) begin
            waddr_n = (state_n == FILL) ? cnt_n : {cur_y_n, cur_x_n};
            wdata_n = color_n;
        end
    end

endmodule
